// File: rtl/pmod_als_spi_scheduler.sv
// pmod_als_spi_scheduler: SPI sequencing master for the Pmod ALS light sensor.
// Schedules conversions from a free-running period timer (auto_en) and from
// single-cycle requests, captures the 16-bit frame and strobes out the 8-bit
// light value.
// Optional build macro PMOD_ALS_SCHEDULER_AVERAGE_EN: when defined, sample is
// the truncated mean of the last four frames' light fields.
//
// state | meaning
// IDLE  | cs high, waiting for a pending trigger
// SETUP | cs low, sck high for CLK_DIV cycles before the first falling edge
// SHIFT | 16 sck periods (low phase then high phase), sdo captured at end of high
// HOLD  | cs high quiet time of 2*CLK_DIV cycles, busy still asserted
module pmod_als_spi_scheduler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_en,
  input  logic        req,
  output logic        cs,
  output logic        sck,
  input  logic        sdo,
  output logic        busy,
  output logic [15:0] raw,
  output logic [7:0]  sample,
  output logic        sample_valid,
  output logic        frame_error
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] PER_ONE   = PW'(1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          high_q, high_d;
  logic [3:0]    bit_q, bit_d;
  logic          pending_q;
  logic [PW-1:0] per_cnt_q;
  logic          sdo_meta, sdo_sync;
  logic [14:0]   shift_q;
  logic [15:0]   shift_next;
  logic          shift_en;
  logic          frame_done;
  logic          start;
  logic          tick;
  logic          trigger;
  logic [7:0]    sample_d;

  assign tick       = auto_en && (per_cnt_q == '0);
  assign trigger    = pending_q || req || tick;
  assign shift_next = {shift_q, sdo_sync};

  // Two-flop synchronizer for the asynchronous sensor data line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sdo_meta <= 1'b0;
      sdo_sync <= 1'b0;
    end else begin
      sdo_meta <= sdo;
      sdo_sync <= sdo_meta;
    end
  end

  // Period timer: held at full count while disabled, ticks and reloads at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      per_cnt_q <= PER_LAST;
    end else if (!auto_en || per_cnt_q == '0) begin
      per_cnt_q <= PER_LAST;
    end else begin
      per_cnt_q <= per_cnt_q - PER_ONE;
    end
  end

  // Pending flag: coalesces triggers, cleared when a transaction starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
    end else if (start) begin
      pending_q <= 1'b0;
    end else if (req || tick) begin
      pending_q <= 1'b1;
    end
  end

  // FSM and phase counters state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      high_q  <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      bit_q   <= bit_d;
    end
  end

  // Next-state logic and SPI pin outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_d     = high_q;
    bit_d      = bit_q;
    cs         = 1'b1;
    sck        = 1'b1;
    busy       = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    start      = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = SETUP;
          cnt_d   = DIV_LAST;
          start   = 1'b1;
        end
      end
      SETUP: begin
        cs   = 1'b0;
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = SHIFT;
          cnt_d   = DIV_LAST;
          high_d  = 1'b0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SHIFT: begin
        cs   = 1'b0;
        busy = 1'b1;
        sck  = high_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!high_q) begin
          high_d = 1'b1;
          cnt_d  = DIV_LAST;
        end else begin
          shift_en = 1'b1;
          if (bit_q == 4'd15) begin
            state_d    = HOLD;
            cnt_d      = HOLD_LAST;
            frame_done = 1'b1;
          end else begin
            bit_d  = bit_q + 4'd1;
            high_d = 1'b0;
            cnt_d  = DIV_LAST;
          end
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register: the newest bit always enters at bit 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= shift_next[14:0];
    end
  end

`ifdef PMOD_ALS_SCHEDULER_AVERAGE_EN
  logic [7:0] hist_q [4];
  logic [7:0] hist_d [4];
  logic       hist_valid_q;
  logic [9:0] hist_sum;

  // Next history window; the first frame after reset fills every slot.
  always_comb begin
    hist_d[0] = shift_next[12:5];
    for (int i = 1; i < 4; i++) begin
      hist_d[i] = hist_valid_q ? hist_q[i-1] : shift_next[12:5];
    end
    hist_sum = {2'b00, hist_d[0]} + {2'b00, hist_d[1]} +
               {2'b00, hist_d[2]} + {2'b00, hist_d[3]};
    sample_d = hist_sum[9:2];
  end

  // History registers advance once per completed frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
    end else if (frame_done) begin
      hist_valid_q <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end
`else
  assign sample_d = shift_next[12:5];
`endif

  // Result registers, updated together with the one-cycle valid strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sample_valid <= frame_done;
      if (frame_done) begin
        raw         <= shift_next;
        sample      <= sample_d;
        frame_error <= |shift_next[15:13];
      end
    end
  end

endmodule
